// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone-controlled 32-bit timer with prescaler and compare match.
// Optional feature macro: WB_TIMER_IRQ_EN. When it is defined, CTRL bit 2 (IRQ_EN) is stored and
// irq_o is driven by a registered MATCH & IRQ_EN. When it is undefined, irq_o is tied low
// and CTRL bit 2 reads 0.
module wb_timer_slave #(
  parameter int PRESC_W = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [31:0] s_wb_addr_i,
  input  logic [31:0] s_wb_data_i,
  output logic [31:0] s_wb_data_o,
  input  logic        s_wb_we_i,
  input  logic        s_wb_cyc_i,
  input  logic        s_wb_stb_i,
  output logic        s_wb_ack_o,
  output logic        irq_o
);

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_PRESC   = 3'd1;
  localparam logic [2:0] IDX_COUNT   = 3'd2;
  localparam logic [2:0] IDX_COMPARE = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;

  // Register state
  logic               ack_reg;
  logic [31:0]        rdata_reg,    rdata_next;
  logic               en_reg;
  logic               auto_reg;
  logic [PRESC_W-1:0] prescale_reg;
  logic [PRESC_W-1:0] presc_cnt_reg, presc_cnt_next;
  logic [31:0]        count_reg,    count_next;
  logic [31:0]        compare_reg;
  logic               match_reg,    match_next;
  logic               irq_en_bit;

  // Bus decode
  logic [2:0] idx;
  logic       accept;
  logic       wr_en;
  logic       rd_en;
  logic       wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic       tick;
  logic       hit;
  logic       unused_addr;

  // Only the low three address bits select a register; the rest are don't-care.
  assign unused_addr = ^s_wb_addr_i[31:3];

  assign idx        = s_wb_addr_i[2:0];
  // A cycle already being acknowledged is not accepted again, which paces a held strobe
  // to one ack every two clocks.
  assign accept     = s_wb_cyc_i & s_wb_stb_i & ~ack_reg;
  assign wr_en      = accept & s_wb_we_i;
  assign rd_en      = accept & ~s_wb_we_i;
  assign wr_ctrl    = wr_en && (idx == IDX_CTRL);
  assign wr_presc   = wr_en && (idx == IDX_PRESC);
  assign wr_count   = wr_en && (idx == IDX_COUNT);
  assign wr_compare = wr_en && (idx == IDX_COMPARE);
  assign wr_status  = wr_en && (idx == IDX_STATUS);

  // Tick and match use the current register values, so CTRL/COMPARE writes landing on the
  // same edge only affect the following tick.
  assign tick = en_reg && (presc_cnt_reg == prescale_reg);
  assign hit  = tick && (count_reg == compare_reg);

  // Next-state logic for prescaler, counter, match flag and read data
  always_comb begin
    presc_cnt_next = presc_cnt_reg + PRESC_W'(1);
    if (wr_presc || !en_reg || tick) begin
      presc_cnt_next = '0;
    end

    count_next = count_reg;
    if (wr_count) begin
      count_next = s_wb_data_i;
    end else if (tick) begin
      count_next = (hit && auto_reg) ? 32'd0 : count_reg + 32'd1;
    end

    match_next = match_reg;
    if (hit) begin
      match_next = 1'b1;
    end else if (wr_status && s_wb_data_i[0]) begin
      match_next = 1'b0;
    end

    rdata_next = 32'd0;
    case (idx)
      IDX_CTRL:    rdata_next = {29'd0, irq_en_bit, auto_reg, en_reg};
      IDX_PRESC:   rdata_next = 32'(prescale_reg);
      IDX_COUNT:   rdata_next = count_reg;
      IDX_COMPARE: rdata_next = compare_reg;
      IDX_STATUS:  rdata_next = {31'd0, match_reg};
      default:     rdata_next = 32'd0;
    endcase
  end

  // Bus handshake, register file and timer state
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ack_reg       <= 1'b0;
      rdata_reg     <= 32'd0;
      en_reg        <= 1'b0;
      auto_reg      <= 1'b0;
      prescale_reg  <= '0;
      presc_cnt_reg <= '0;
      count_reg     <= 32'd0;
      compare_reg   <= 32'd0;
      match_reg     <= 1'b0;
    end else begin
      ack_reg       <= accept;
      presc_cnt_reg <= presc_cnt_next;
      count_reg     <= count_next;
      match_reg     <= match_next;
      if (rd_en) begin
        rdata_reg <= rdata_next;
      end
      if (wr_ctrl) begin
        en_reg   <= s_wb_data_i[0];
        auto_reg <= s_wb_data_i[1];
      end
      if (wr_presc) begin
        prescale_reg <= s_wb_data_i[PRESC_W-1:0];
      end
      if (wr_compare) begin
        compare_reg <= s_wb_data_i;
      end
    end
  end

`ifdef WB_TIMER_IRQ_EN
  logic irq_en_reg;
  logic irq_reg;

  // Interrupt enable bit and registered level interrupt
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en_reg <= s_wb_data_i[2];
      end
      irq_reg <= match_reg & irq_en_reg;
    end
  end

  assign irq_en_bit = irq_en_reg;
  assign irq_o      = irq_reg;
`else
  assign irq_en_bit = 1'b0;
  assign irq_o      = 1'b0;
`endif

  assign s_wb_ack_o  = ack_reg;
  assign s_wb_data_o = rdata_reg;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Testbench for wb_timer_slave: directed bus transactions feed a scoreboard queue that a
// negedge monitor drains on every ack; timing-sensitive signals are checked inline.
module tb_wb_timer_slave;

`ifdef WB_TIMER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        we_s = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  logic prev_ack = 1'b0;

  wb_timer_slave #(.PRESC_W(16)) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .s_wb_addr_i (addr),
    .s_wb_data_i (wdata),
    .s_wb_data_o (rdata),
    .s_wb_we_i   (we_s),
    .s_wb_cyc_i  (cyc),
    .s_wb_stb_i  (stb),
    .s_wb_ack_o  (ack),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response; read data and ack width are compared.
  always @(negedge clk) begin
    sb_t e;
    if (ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack (queue empty)");
      end else begin
        e = sb_q.pop_front();
        n_vec++;
        if (prev_ack !== 1'b0) begin
          n_err++;
          $display("FAIL ack_width_%s: got ack high 2 cycles expected 1", e.name);
        end
        if (e.is_rd) begin
          n_vec++;
          if (rdata !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, rdata, e.exp);
          end else begin
            $display("rd %-14s data=%h", e.name, rdata);
          end
        end else begin
          $display("wr %-14s acked", e.name);
        end
      end
    end
    prev_ack = ack;
  end

  // Push the expected response, drive the access, return 1 ns after the accepting edge.
  task automatic wb_accept(input bit we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic [31:0] exp, input string name);
    sb_t e;
    e.is_rd = !we;
    e.exp   = exp;
    e.name  = name;
    sb_q.push_back(e);
    cyc   = 1'b1;
    stb   = 1'b1;
    we_s  = we;
    addr  = {29'd0, idx};
    wdata = wd;
    @(posedge clk);
    #1;
    cyc  = 1'b0;
    stb  = 1'b0;
    we_s = 1'b0;
  endtask

  // One complete access: accepted at the next posedge, returns on the edge that ends the ack.
  task automatic wb_xfer(input bit we, input logic [2:0] idx, input logic [31:0] wd,
                         input logic [31:0] exp, input string name);
    @(negedge clk);
    wb_accept(we, idx, wd, exp, name);
    @(posedge clk);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd, input string name);
    wb_xfer(1'b1, idx, wd, 32'd0, name);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, idx, 32'd0, exp, name);
  endtask

  initial begin
    sb_t e;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Release reset and issue the first read on the very next edge
    @(negedge clk);
    nrst = 1'b1;
    wb_accept(1'b0, 3'd0, 32'd0, 32'd0, "rst_ctrl");
    @(posedge clk);
    rd(3'd1, 32'd0, "rst_presc");
    rd(3'd2, 32'd0, "rst_count");
    rd(3'd3, 32'd0, "rst_compare");
    rd(3'd4, 32'd0, "rst_status");

    // Auto-reload at COMPARE=5, tick every cycle: odd samples of the count sequence
    wr(3'd3, 32'd5, "cmp5");
    wr(3'd1, 32'd0, "presc0");
    wr(3'd0, 32'd3, "ctrl_en_auto");
    rd(3'd2, 32'd1, "ar_count1");
    rd(3'd4, 32'd0, "ar_nomatch");
    rd(3'd2, 32'd5, "ar_count5");
    rd(3'd4, 32'd1, "ar_match");
    rd(3'd2, 32'd3, "ar_reloaded");

    // Same run shifted by one cycle: even samples 2, 4, then reload to 0
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd2, 32'd0, "count0");
    wr(3'd4, 32'd1, "clr_match");
    wr(3'd0, 32'd3, "ctrl_en_auto");
    @(posedge clk);
    rd(3'd2, 32'd2, "ar_count2");
    rd(3'd2, 32'd4, "ar_count4");
    rd(3'd2, 32'd0, "ar_count0");
    rd(3'd4, 32'd1, "ar_match2");

    // 32-bit wrap with PRESCALE=3, no auto-reload, no match
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd4, 32'd1, "clr_match");
    wr(3'd2, 32'hFFFF_FFFF, "count_max");
    wr(3'd3, 32'h10, "cmp16");
    wr(3'd1, 32'd3, "presc3");
    wr(3'd0, 32'd1, "ctrl_en");
    rd(3'd2, 32'hFFFF_FFFF, "wrap_pre1");
    rd(3'd2, 32'hFFFF_FFFF, "wrap_pre2");
    rd(3'd2, 32'd0, "wrap_zero");
    rd(3'd4, 32'd0, "wrap_nomatch");
    rd(3'd2, 32'd1, "wrap_next");

    // MATCH set on the same edge as a STATUS clear wins; a later clear succeeds
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd4, 32'd1, "clr_match");
    wr(3'd2, 32'd0, "count0");
    wr(3'd3, 32'd2, "cmp2");
    wr(3'd1, 32'd0, "presc0");
    wr(3'd0, 32'd3, "ctrl_en_auto");
    rd(3'd4, 32'd0, "st_before");
    rd(3'd4, 32'd1, "st_pending");
    wr(3'd4, 32'd1, "clr_on_match");
    rd(3'd4, 32'd1, "st_match_wins");
    wr(3'd4, 32'd1, "clr_no_match");
    rd(3'd4, 32'd0, "st_cleared");
    wr(3'd0, 32'd0, "ctrl_off");
    wr(3'd4, 32'd0, "status_bit0_0");
    rd(3'd4, 32'd1, "st_kept");
    wr(3'd4, 32'd1, "clr_match");
    rd(3'd4, 32'd0, "st_clr2");
    rd(3'd2, 32'd2, "count_frozen");

    // Unimplemented indices and bits
    rd(3'd5, 32'd0, "idx5");
    rd(3'd6, 32'd0, "idx6");
    wr(3'd7, 32'hABCD_1234, "idx7_write");
    rd(3'd0, 32'd0, "idx7_ctrl");
    rd(3'd1, 32'd0, "idx7_presc");
    rd(3'd3, 32'd2, "idx7_compare");
    rd(3'd2, 32'd2, "idx7_count");
    wr(3'd1, 32'hFFFF_FFFF, "presc_all1");
    rd(3'd1, 32'h0000_FFFF, "presc_width");
    wr(3'd1, 32'd0, "presc0");

    // Held strobe for four edges: exactly two acks
    @(negedge clk);
    e.is_rd = 1'b1; e.exp = 32'd2; e.name = "hold_rd1";
    sb_q.push_back(e);
    e.name = "hold_rd2";
    sb_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; addr = 32'd3;
    repeat (4) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);

    // Interrupt timing (or its absence without the feature)
    wr(3'd2, 32'd0, "count0");
    wr(3'd0, 32'd7, "ctrl_7");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
    wr(3'd0, 32'd4, "ctrl_irq_only");
    @(negedge clk);
    wb_accept(1'b1, 3'd4, 32'd1, 32'd0, "clr_irq");
    chk("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
    @(posedge clk);
    #1;
    chk("irq_drop", {31'd0, irq}, 32'd0);
    rd(3'd0, IRQ_ON ? 32'd4 : 32'd0, "ctrl_irqen");
    wr(3'd0, 32'd7, "ctrl_7b");
    rd(3'd0, IRQ_ON ? 32'd7 : 32'd3, "ctrl_rb");

    // Reset asserted during an un-acked strobe
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b1; addr = 32'd3; wdata = 32'h55;
    #1;
    nrst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we_s = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ack", {31'd0, ack}, 32'd0);
    end
    rd(3'd3, 32'd0, "post_rst_cmp");
    rd(3'd0, 32'd0, "post_rst_ctrl");
    rd(3'd2, 32'd0, "post_rst_count");

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_timer_slave.md
WB_TIMER_SLAVE -- requirements
Module: wb_timer_slave

Interface
REQ-001 Parameter PRESC_W, default 16, prescaler register width (1..32).
REQ-002 clk_i  input  1  sole clock; all state on rising edge; also the Wishbone clock.
REQ-003 nrst_i  input  1  asynchronous active-low reset.
REQ-004 s_wb_addr_i  input  32  word address; only bits [2:0] decoded.
REQ-005 s_wb_data_i  input  32  write data.
REQ-006 s_wb_data_o  output  32  read data, registered.
REQ-007 s_wb_we_i  input  1  1 = write, 0 = read.
REQ-008 s_wb_cyc_i  input  1  bus cycle valid.
REQ-009 s_wb_stb_i  input  1  strobe.
REQ-010 s_wb_ack_o  output  1  single-cycle acknowledge.
REQ-011 irq_o  output  1  level interrupt.

Function
REQ-012 Register map (word index): 0 CTRL {EN[0], AUTO_RELOAD[1], IRQ_EN[2]}; 1 PRESCALE[PRESC_W-1:0]; 2 COUNT[31:0]; 3 COMPARE[31:0]; 4 STATUS {MATCH[0]}.
REQ-013 Unimplemented bits read 0; indices 5..7 read 0x00000000, writes ignored, still acked.
REQ-014 Access accepted on an edge where cyc & stb & !ack; ack = 1 for exactly the following cycle, then 0; a held strobe yields one ack every 2 cycles.
REQ-015 Write takes effect at the accepting edge; read data latched at the accepting edge, presented with ack, held until next accepted read.
REQ-016 cyc or stb dropped before ack: no access, no ack.
REQ-017 Prescaler counter counts 0..PRESCALE, wraps to 0; tick = 1 cycle when counter equals PRESCALE and EN = 1; PRESCALE = 0 gives a tick every cycle.
REQ-018 EN = 0: prescaler counter held at 0, COUNT frozen, no ticks.
REQ-019 On tick: COUNT == COMPARE sets MATCH; COUNT becomes 0 if match and AUTO_RELOAD, else COUNT+1 modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
REQ-020 Wishbone write to COUNT on a tick edge: written value wins, tick's increment discarded.
REQ-021 STATUS write with bit0 = 1 clears MATCH; bit0 = 0 no effect; a match on the same edge wins (MATCH stays 1).
REQ-022 Write to PRESCALE resets the prescaler counter to 0 on the same edge.
REQ-023 COMPARE/CTRL changes affect the next tick, not one already in progress on the same edge.

Reset
REQ-024 nrst_i low asynchronously clears all registers, prescaler counter, MATCH, s_wb_ack_o, s_wb_data_o, irq_o to 0.
REQ-025 Reset mid-transaction aborts it; no ack is produced after release for the aborted access.
REQ-026 First access accepted on the first rising edge with nrst_i high and cyc & stb.

Configuration
REQ-027 Macro WB_TIMER_IRQ_EN defined: irq_o = registered MATCH & IRQ_EN (asserts cycle after MATCH sets, clears cycle after MATCH or IRQ_EN clears).
REQ-028 WB_TIMER_IRQ_EN undefined: irq_o tied 0, CTRL bit 2 not stored and reads 0; all else unchanged.

Verification
REQ-029 After reset, read indices 0..4 -> all return 0x00000000, each ack exactly 1 cycle wide.
REQ-030 Write COMPARE = 5, PRESCALE = 0, CTRL = 0x3 -> MATCH set on the 6th tick after enable; COUNT sequence 0,1,2,3,4,5,0,1...
REQ-031 Write COUNT = 0xFFFFFFFF, COMPARE = 0x10, PRESCALE = 3, CTRL = 0x1 -> COUNT reads 0x00000000 four cycles after enable, MATCH stays 0.
REQ-032 Match pending, write STATUS = 0x1 on the same edge as a new match -> MATCH remains 1; later STATUS = 0x1 write with no match -> MATCH reads 0.
REQ-033 With WB_TIMER_IRQ_EN, CTRL = 0x7, COMPARE = 2 -> irq_o rises one cycle after MATCH; clearing STATUS drops irq_o next cycle; without macro irq_o stays 0 and CTRL reads 0x3.
REQ-034 Read index 6, write 0xABCD1234 to index 7, assert nrst_i low during an un-acked strobe -> reads 0, no state change, no ack after reset release.
